feature_frame_loader: RTL and testbench
=======================================

// Module: feature_frame_loader
// PURPOSE
//   Upstream stage of the combinational classifier `top`.
//   - Accepts one WIDTH_A-bit feature per valid/ready handshake and packs NUM_A features into `inp`.
//   - Holds `inp` stable for SETTLE_CYC cycles, then registers the classifier's `out` as a result.
//   - Presents the result on a valid/ready output and rejects malformed frames.
// PARAMETERS
//   NUM_A       6  features per frame
//   WIDTH_A     4  bits per feature (unsigned)
//   OUTWIDTH    2  classifier class width
//   SETTLE_CYC  2  cycles `inp` is held before sampling cls_in; legal range >=1
// PORTS
//   clk         in   1                clock; all state updates on its rising edge
//   rst_n       in   1                asynchronous reset, active low
//   feat_valid  in   1                feature word valid
//   feat_data   in   WIDTH_A          feature value
//   feat_last   in   1                marks the final feature of a frame
//   feat_ready  out  1                loader can accept a feature
//   inp         out  NUM_A*WIDTH_A    packed vector to classifier `inp`
//   cls_in      in   OUTWIDTH         classifier `out`, fed back
//   res_valid   out  1                res_class valid
//   res_class   out  OUTWIDTH         registered class of the last frame
//   res_ready   in   1                downstream accepts the result
//   frame_err   out  1                1-cycle pulse: malformed frame dropped
// BEHAVIOUR
//   Reset, async while rst_n=0:
//   - state=COLLECT, idx=0, inp=0, res_class=0, res_valid=0, frame_err=0.
//   - feat_ready=1 (see below).
//   feat_ready = (state==COLLECT), combinational from state.
//   FSM COLLECT -> SETTLE -> EMIT -> COLLECT.
//   COLLECT: on feat_valid&&feat_ready:
//   - feat_data is written to inp[(idx+1)*WIDTH_A-1 : idx*WIDTH_A].
//   - feature 0 goes to the LSBs.
//   - idx<NUM_A-1 and feat_last=0: idx<=idx+1.
//   - idx==NUM_A-1 and feat_last=1: idx<=0, cnt<=0, state<=SETTLE.
//   - feat_last=1 with idx<NUM_A-1: error. Also an error: idx==NUM_A-1 with feat_last=0.
//   - On error: frame_err=1 next cycle for 1 cycle, idx<=0, inp<=0, stay in COLLECT.
//   - No beat: idx, inp and state are unchanged.
//   SETTLE: feat_ready=0 and inp is stable.
//   - cnt increments each cycle.
//   - At the edge where cnt==SETTLE_CYC-1: res_class<=cls_in, res_valid<=1, state<=EMIT.
//   EMIT: res_valid=1, res_class and inp are held.
//   - On res_valid&&res_ready: res_valid<=0, state<=COLLECT.
//   - The next frame can start the following cycle.
//   - res_valid never drops without a handshake.
//   Latency: last feature accepted at edge T -> res_valid=1 after edge T+SETTLE_CYC.
//   - Minimum frame period is NUM_A+SETTLE_CYC+1 cycles (res_ready=1).
//   feat_* inputs are ignored outside COLLECT. Nothing is buffered and no overflow is possible.
//   cls_in is sampled only at the SETTLE exit edge. Its value at other times is don't-care.
//   rst_n low mid-frame or mid-EMIT: the partial frame and any pending result are discarded.
//   - All outputs return to reset values immediately.
//   Counter widths:
//   - idx: $clog2(NUM_A).
//   - cnt: $clog2(SETTLE_CYC+1).
//   - Neither ever wraps within a frame.
// TESTING
//   1. Feed 1,2,3,4,5,6 (last on 6), stub cls_in=2'd2.
//      -> inp=24'h654321; res_valid rises 2 cycles after the 6th beat; res_class=2.
//   2. Hold res_ready=0 for 5 cycles in EMIT.
//      -> res_valid and res_class held; feat_ready=0; inp unchanged; completes on the handshake.
//   3. feat_last with the 4th feature.
//      -> frame_err pulses once; inp=0; idx=0; the next good frame classifies correctly.
//   4. 6th feature without feat_last.
//      -> frame_err pulse; no res_valid; loader returns to COLLECT.
//   5. Drop rst_n during SETTLE.
//      -> outputs at reset values at once; after release a fresh frame gives the correct result.
//   6. Three back-to-back frames with res_ready=1 and feat_valid held high.
//      -> 3 results, one every 9 cycles; feat_data is ignored while feat_ready=0.

Source files
------------

// File: rtl/feature_frame_loader_if.sv
// Handshake bundle between the feature source, the frame loader, the
// combinational classifier and the result consumer.
// The loader takes the slave view. The source/consumer side takes the master view.
interface feature_frame_loader_if #(
   parameter int NUM_A    = 6,
   parameter int WIDTH_A  = 4,
   parameter int OUTWIDTH = 2
);
   logic                     feat_valid;
   logic [WIDTH_A-1:0]       feat_data;
   logic                     feat_last;
   logic                     feat_ready;
   logic [NUM_A*WIDTH_A-1:0] inp;
   logic [OUTWIDTH-1:0]      cls_in;
   logic                     res_valid;
   logic [OUTWIDTH-1:0]      res_class;
   logic                     res_ready;
   logic                     frame_err;

   modport slave (
      input  feat_valid, feat_data, feat_last, cls_in, res_ready,
      output feat_ready, inp, res_valid, res_class, frame_err
   );

   modport master (
      output feat_valid, feat_data, feat_last, cls_in, res_ready,
      input  feat_ready, inp, res_valid, res_class, frame_err
   );
endinterface

// File: rtl/feature_frame_loader.sv
// Frame loader in front of the combinational classifier.
// It packs NUM_A features into inp, feature 0 in the LSBs.
// It holds inp for SETTLE_CYC cycles so the classifier output can settle.
// It then captures the class and offers it on a valid/ready result port.
// A frame whose feat_last marker is not on exactly the NUM_A-th feature is dropped.
// The drop is flagged with a one-cycle frame_err pulse.
module feature_frame_loader #(
   parameter int NUM_A      = 6,
   parameter int WIDTH_A    = 4,
   parameter int OUTWIDTH   = 2,
   parameter int SETTLE_CYC = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   feature_frame_loader_if.slave bus
);

   localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
   localparam int CNT_W = $clog2(SETTLE_CYC + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_A - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SETTLE  = 2'd1,
      EMIT    = 2'd2
   } state_t;

   state_t                   state, state_next;
   logic [IDX_W-1:0]         idx, idx_next;
   logic [CNT_W-1:0]         cnt, cnt_next;
   logic [NUM_A*WIDTH_A-1:0] inp_q, inp_next;
   logic [OUTWIDTH-1:0]      res_class_q, res_class_next;
   logic                     res_valid_q, res_valid_next;
   logic                     frame_err_q, frame_err_next;

   // Loader is only willing to take features while it is assembling a frame
   assign bus.feat_ready = (state == COLLECT);
   assign bus.inp        = inp_q;
   assign bus.res_class  = res_class_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.frame_err  = frame_err_q;

   // State register; reset discards any partial frame or pending result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= COLLECT;
         idx         <= '0;
         cnt         <= '0;
         inp_q       <= '0;
         res_class_q <= '0;
         res_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state       <= state_next;
         idx         <= idx_next;
         cnt         <= cnt_next;
         inp_q       <= inp_next;
         res_class_q <= res_class_next;
         res_valid_q <= res_valid_next;
         frame_err_q <= frame_err_next;
      end
   end

   // Next-state logic: frame assembly, settle countdown and result handshake
   always_comb begin
      state_next     = state;
      idx_next       = idx;
      cnt_next       = cnt;
      inp_next       = inp_q;
      res_class_next = res_class_q;
      res_valid_next = res_valid_q;
      frame_err_next = 1'b0;

      case (state)
         COLLECT: begin
            if (bus.feat_valid) begin
               if ((idx == IDX_LAST) && bus.feat_last) begin
                  inp_next[idx*WIDTH_A +: WIDTH_A] = bus.feat_data;
                  idx_next   = '0;
                  cnt_next   = '0;
                  state_next = SETTLE;
               end else if ((idx != IDX_LAST) && !bus.feat_last) begin
                  inp_next[idx*WIDTH_A +: WIDTH_A] = bus.feat_data;
                  idx_next = idx + IDX_W'(1);
               end else begin
                  // The last marker is early or missing, so the whole frame is dropped
                  frame_err_next = 1'b1;
                  idx_next       = '0;
                  inp_next       = '0;
               end
            end
         end

         SETTLE: begin
            cnt_next = cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
               res_class_next = bus.cls_in;
               res_valid_next = 1'b1;
               state_next     = EMIT;
            end
         end

         EMIT: begin
            if (bus.res_ready) begin
               res_valid_next = 1'b0;
               state_next     = COLLECT;
            end
         end

         default: begin
            state_next = COLLECT;
         end
      endcase
   end

endmodule

// File: tb/tb_feature_frame_loader.sv
// Self-checking bench for feature_frame_loader.
// A queue of expected results is filled as frames are sent.
// Entries are popped when res_valid is seen.
// The classifier is stubbed with a constant or with "sum of features mod 4".
module tb_feature_frame_loader;

   typedef struct {
      logic [23:0] inp;
      logic [1:0]  cls;
   } exp_t;

   logic clk;
   logic rst_n;
   logic stub_en;
   logic [1:0] stub_val;
   int passed;
   int total;
   exp_t sb[$];

   feature_frame_loader_if #(.NUM_A(6), .WIDTH_A(4), .OUTWIDTH(2)) bus ();

   feature_frame_loader #(
      .NUM_A(6), .WIDTH_A(4), .OUTWIDTH(2), .SETTLE_CYC(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [1:0] cls_of(input logic [23:0] v);
      int s;
      s = 0;
      for (int i = 0; i < 6; i++) s += int'(v[i*4 +: 4]);
      return 2'(s);
   endfunction

   // Classifier stand-in driven from the loader's packed vector
   always_comb begin
      bus.cls_in = stub_en ? stub_val : cls_of(bus.inp);
   end

   // Offers one feature at a negedge and returns at the negedge after it is taken
   task automatic send_beat(input logic [3:0] d, input logic l);
      int guard;
      bus.feat_valid = 1'b1;
      bus.feat_data  = d;
      bus.feat_last  = l;
      guard = 0;
      while (bus.feat_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         total++;
         $display("[TB] FAIL beat_timeout: feat_ready got %b required 1", bus.feat_ready);
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [23:0] v, input int n, input int last_at,
                             input bit push, input logic [1:0] cls_exp);
      exp_t e;
      if (push) begin
         e.inp = v;
         e.cls = cls_exp;
         sb.push_back(e);
      end
      for (int i = 0; i < n; i++) send_beat(v[i*4 +: 4], (i == last_at));
      bus.feat_valid = 1'b0;
      bus.feat_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.feat_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b required 1", bus.feat_ready); else passed++;
      total++; if (bus.res_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b required 0", bus.res_valid); else passed++;
      total++; if (bus.res_class !== 2'd0) $display("[TB] FAIL reset_class: got %0d required 0", bus.res_class); else passed++;
      total++; if (bus.inp !== 24'h0) $display("[TB] FAIL reset_inp: got %h required 000000", bus.inp); else passed++;
      total++; if (bus.frame_err !== 1'b0) $display("[TB] FAIL reset_err: got %b required 0", bus.frame_err); else passed++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_frame();
      exp_t e;
      stub_en  = 1'b1;
      stub_val = 2'd2;
      bus.res_ready = 1'b0;
      send_frame(24'h654321, 6, 5, 1'b1, 2'd2);
      total++; if (bus.inp !== 24'h654321) $display("[TB] FAIL basic_inp: got %h required 654321", bus.inp); else passed++;
      total++; if (bus.res_valid !== 1'b0) $display("[TB] FAIL basic_early0: got %b required 0", bus.res_valid); else passed++;
      @(negedge clk);
      total++; if (bus.res_valid !== 1'b0) $display("[TB] FAIL basic_early1: got %b required 0", bus.res_valid); else passed++;
      @(negedge clk);
      total++; if (bus.res_valid !== 1'b1) $display("[TB] FAIL basic_latency: got %b required 1", bus.res_valid); else passed++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total++; if (bus.res_class !== e.cls) $display("[TB] FAIL basic_class: got %0d required %0d", bus.res_class, e.cls); else passed++;
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      total++; if (bus.res_valid !== 1'b0) $display("[TB] FAIL basic_drop: got %b required 0", bus.res_valid); else passed++;
      total++; if (bus.feat_ready !== 1'b1) $display("[TB] FAIL basic_back: got %b required 1", bus.feat_ready); else passed++;
      stub_en = 1'b0;
   endtask

   task automatic test_backpressure();
      exp_t e;
      int w;
      bus.res_ready = 1'b0;
      send_frame(24'h82F936, 6, 5, 1'b1, cls_of(24'h82F936));
      w = 0;
      while (bus.res_valid !== 1'b1 && w < 30) begin @(negedge clk); w++; end
      total++; if (w >= 30) $display("[TB] FAIL bp_timeout: res_valid got %b required 1", bus.res_valid); else passed++;
      e = sb.pop_front();
      for (int c = 0; c < 5; c++) begin
         bus.feat_valid = 1'b1;
         bus.feat_data  = 4'(c + 9);
         bus.feat_last  = c[0];
         total++; if (bus.res_valid !== 1'b1 || bus.res_class !== e.cls) $display("[TB] FAIL bp_hold: valid/class got %b/%0d required 1/%0d", bus.res_valid, bus.res_class, e.cls); else passed++;
         total++; if (bus.feat_ready !== 1'b0 || bus.inp !== e.inp) $display("[TB] FAIL bp_stall: ready/inp got %b/%h required 0/%h", bus.feat_ready, bus.inp, e.inp); else passed++;
         @(negedge clk);
      end
      bus.feat_valid = 1'b0;
      bus.feat_last  = 1'b0;
      bus.res_ready  = 1'b1;
      @(negedge clk);
      bus.res_ready  = 1'b0;
      total++; if (bus.res_valid !== 1'b0 || bus.feat_ready !== 1'b1) $display("[TB] FAIL bp_release: valid/ready got %b/%b required 0/1", bus.res_valid, bus.feat_ready); else passed++;
   endtask

   task automatic test_early_last();
      exp_t e;
      int w;
      send_frame(24'h004321, 4, 3, 1'b0, 2'd0);
      total++; if (bus.frame_err !== 1'b1) $display("[TB] FAIL early_err: got %b required 1", bus.frame_err); else passed++;
      total++; if (bus.inp !== 24'h0) $display("[TB] FAIL early_inp: got %h required 000000", bus.inp); else passed++;
      @(negedge clk);
      total++; if (bus.frame_err !== 1'b0) $display("[TB] FAIL early_pulse: got %b required 0", bus.frame_err); else passed++;
      bus.res_ready = 1'b1;
      send_frame(24'hA5C3E1, 6, 5, 1'b1, cls_of(24'hA5C3E1));
      w = 0;
      while (bus.res_valid !== 1'b1 && w < 30) begin @(negedge clk); w++; end
      total++; if (w >= 30) $display("[TB] FAIL early_timeout: res_valid got %b required 1", bus.res_valid); else passed++;
      e = sb.pop_front();
      total++; if (bus.res_class !== e.cls || bus.inp !== e.inp) $display("[TB] FAIL early_recover: class/inp got %0d/%h required %0d/%h", bus.res_class, bus.inp, e.cls, e.inp); else passed++;
      @(negedge clk);
      bus.res_ready = 1'b0;
   endtask

   task automatic test_missing_last();
      bit saw_valid;
      send_frame(24'h123456, 6, -1, 1'b0, 2'd0);
      total++; if (bus.frame_err !== 1'b1) $display("[TB] FAIL miss_err: got %b required 1", bus.frame_err); else passed++;
      saw_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.res_valid === 1'b1) saw_valid = 1'b1;
      end
      total++; if (saw_valid) $display("[TB] FAIL miss_valid: res_valid seen 1 required 0"); else passed++;
      total++; if (bus.feat_ready !== 1'b1 || bus.inp !== 24'h0) $display("[TB] FAIL miss_collect: ready/inp got %b/%h required 1/000000", bus.feat_ready, bus.inp); else passed++;
   endtask

   task automatic test_reset_settle();
      exp_t e;
      int w;
      send_frame(24'h9ABCDE, 6, 5, 1'b1, cls_of(24'h9ABCDE));
      total++; if (bus.feat_ready !== 1'b0) $display("[TB] FAIL rs_settle: ready got %b required 0", bus.feat_ready); else passed++;
      rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      total++; if (bus.res_valid !== 1'b0 || bus.res_class !== 2'd0) $display("[TB] FAIL rs_out: valid/class got %b/%0d required 0/0", bus.res_valid, bus.res_class); else passed++;
      total++; if (bus.feat_ready !== 1'b1 || bus.inp !== 24'h0) $display("[TB] FAIL rs_inp: ready/inp got %b/%h required 1/000000", bus.feat_ready, bus.inp); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b1;
      send_frame(24'h3579BD, 6, 5, 1'b1, cls_of(24'h3579BD));
      w = 0;
      while (bus.res_valid !== 1'b1 && w < 30) begin @(negedge clk); w++; end
      total++; if (w >= 30) $display("[TB] FAIL rs_timeout: res_valid got %b required 1", bus.res_valid); else passed++;
      e = sb.pop_front();
      total++; if (bus.res_class !== e.cls || bus.inp !== e.inp) $display("[TB] FAIL rs_fresh: class/inp got %0d/%h required %0d/%h", bus.res_class, bus.inp, e.cls, e.inp); else passed++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [23:0] frames[3];
      int stamp[3];
      int k, got, cyc;
      exp_t e;
      frames[0] = 24'h111111;
      frames[1] = 24'hFEDCBA;
      frames[2] = 24'h0F0F0F;
      k = 0; got = 0; cyc = 0;
      bus.res_ready = 1'b1;
      while (got < 3 && cyc < 100) begin
         if (bus.res_valid === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               $display("[TB] FAIL b2b_extra: unexpected result class %0d", bus.res_class);
            end else begin
               e = sb.pop_front();
               total++; if (bus.res_class !== e.cls || bus.inp !== e.inp) $display("[TB] FAIL b2b_result: class/inp got %0d/%h required %0d/%h", bus.res_class, bus.inp, e.cls, e.inp); else passed++;
            end
            stamp[got] = cyc;
            got++;
         end
         if (bus.feat_ready === 1'b1 && k < 18) begin
            if (k % 6 == 0) begin
               e.inp = frames[k/6];
               e.cls = cls_of(frames[k/6]);
               sb.push_back(e);
            end
            bus.feat_valid = 1'b1;
            bus.feat_data  = frames[k/6][(k%6)*4 +: 4];
            bus.feat_last  = (k % 6 == 5);
            k++;
         end else if (k < 18) begin
            bus.feat_valid = 1'b1;
            bus.feat_data  = 4'($urandom);
            bus.feat_last  = 1'($urandom);
         end else begin
            bus.feat_valid = 1'b0;
            bus.feat_last  = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      bus.feat_valid = 1'b0;
      bus.feat_last  = 1'b0;
      total++; if (got != 3) $display("[TB] FAIL b2b_count: got %0d results required 3", got); else passed++;
      if (got == 3) begin
         total++; if (stamp[1] - stamp[0] != 9) $display("[TB] FAIL b2b_period1: got %0d required 9", stamp[1] - stamp[0]); else passed++;
         total++; if (stamp[2] - stamp[1] != 9) $display("[TB] FAIL b2b_period2: got %0d required 9", stamp[2] - stamp[1]); else passed++;
      end
   endtask

   // Test sequence
   initial begin
      passed = 0;
      total  = 0;
      stub_en  = 1'b0;
      stub_val = 2'd0;
      rst_n = 1'b0;
      bus.feat_valid = 1'b0;
      bus.feat_data  = 4'd0;
      bus.feat_last  = 1'b0;
      bus.res_ready  = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_early_last();
      test_missing_last();
      test_reset_settle();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
